collatz_range: RTL and testbench

//  Parametrised Collatz engine. One go loads a base value and a count. The block

---
 rtl/collatz_range_if.sv | 40 ++++
 rtl/collatz_range.sv | 177 +++++++++++++++++
 tb/tb_collatz_range.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/collatz_range_if.sv
// -----------------------------------------------------------------------------
// collatz_range_if
//   Bus bundle between a host and the collatz_range engine: the range request
//   (go/n/count), status (busy/done) and the valid/ready result stream.
//
//   Modports:
//     master : host side   - drives go, n, count, res_ready
//     slave  : engine side - drives busy, done and all res_* result fields
//
//   Parameters match the engine: WIDTH (value width), STEP_W (step counter
//   width), CNT_W (range count width).
// -----------------------------------------------------------------------------
interface collatz_range_if #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 16
);
    logic              go;
    logic [WIDTH-1:0]  n;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_n;
    logic [STEP_W-1:0] res_steps;
    logic              res_ovf;
    logic              res_err;
    logic [WIDTH-1:0]  res_peak;

    modport master (
        output go, n, count, res_ready,
        input  busy, done, res_valid, res_n, res_steps, res_ovf, res_err, res_peak
    );

    modport slave (
        input  go, n, count, res_ready,
        output busy, done, res_valid, res_n, res_steps, res_ovf, res_err, res_peak
    );
endinterface

// File: rtl/collatz_range.sv
// -----------------------------------------------------------------------------
// collatz_range
//   Collatz stopping-time engine over a range of start values. An accepted go
//   captures a base value and a count; the engine then iterates each start
//   value base .. base+count-1 (one Collatz step per clock) and streams one
//   result per value on a valid/ready port, with overflow / error flags and a
//   saturating step count.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : synchronous, active-high; abandons any range in progress
//     bus    : collatz_range_if.slave
//              go/n/count    - range request (ignored while busy)
//              busy/done     - range in progress / one-cycle completion pulse
//              res_valid/res_ready, res_n, res_steps, res_ovf, res_err,
//              res_peak      - result stream
//
//   Optional feature macro: COLLATZ_PEAK_EN
//     defined   : track the maximum trajectory value and report it on res_peak
//     undefined : no peak register, res_peak reads 0
// -----------------------------------------------------------------------------
module collatz_range #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           reset,
    collatz_range_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  base_reg;
    logic [WIDTH-1:0]  cur_reg;
    logic [CNT_W-1:0]  remain_reg;
    logic [STEP_W-1:0] steps_reg;
    logic              ovf_reg;
    logic              err_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              valid_reg;

    // 3*cur+1 in two extra bits so that overflow past WIDTH is observable.
    logic [WIDTH+1:0]  triple;
    logic [STEP_W-1:0] steps_inc;
    logic [WIDTH-1:0]  base_inc;

    assign triple    = {1'b0, cur_reg, 1'b0} + {2'b00, cur_reg}
                     + {{(WIDTH+1){1'b0}}, 1'b1};
    // Step counter sticks at all-ones instead of wrapping.
    assign steps_inc = (&steps_reg) ? steps_reg : steps_reg + STEP_W'(1);
    // Next start value wraps modulo 2^WIDTH; a wrapped 0 is flagged as error.
    assign base_inc  = base_reg + WIDTH'(1);

`ifdef COLLATZ_PEAK_EN
    logic [WIDTH-1:0] peak_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            cur_reg    <= '0;
            remain_reg <= '0;
            steps_reg  <= '0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            valid_reg  <= 1'b0;
`ifdef COLLATZ_PEAK_EN
            peak_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.go) begin
                        if (bus.count == '0) begin
                            // Empty range: just acknowledge.
                            done_reg <= 1'b1;
                        end else begin
                            base_reg   <= bus.n;
                            cur_reg    <= bus.n;
                            remain_reg <= bus.count;
                            steps_reg  <= '0;
                            ovf_reg    <= 1'b0;
                            err_reg    <= 1'b0;
                            busy_reg   <= 1'b1;
`ifdef COLLATZ_PEAK_EN
                            peak_reg   <= bus.n;
`endif
                            state_reg  <= ITER;
                        end
                    end
                end

                ITER: begin
                    if (cur_reg == WIDTH'(1)) begin
                        valid_reg <= 1'b1;
                        state_reg <= EMIT;
                    end else if (cur_reg == '0) begin
                        // 0 is a fixed point of the halving step: never reaches 1.
                        err_reg   <= 1'b1;
                        steps_reg <= '0;
                        valid_reg <= 1'b1;
                        state_reg <= EMIT;
                    end else if (!cur_reg[0]) begin
                        cur_reg   <= cur_reg >> 1;
                        steps_reg <= steps_inc;
                    end else if (triple[WIDTH+1:WIDTH] != 2'b00) begin
                        // Abandon; steps keeps the count completed so far.
                        ovf_reg   <= 1'b1;
                        valid_reg <= 1'b1;
                        state_reg <= EMIT;
                    end else begin
                        cur_reg   <= triple[WIDTH-1:0];
                        steps_reg <= steps_inc;
`ifdef COLLATZ_PEAK_EN
                        // Only an odd step can raise the trajectory maximum.
                        if (triple[WIDTH-1:0] > peak_reg) begin
                            peak_reg <= triple[WIDTH-1:0];
                        end
`endif
                    end
                end

                EMIT: begin
                    if (bus.res_ready) begin
                        valid_reg  <= 1'b0;
                        remain_reg <= remain_reg - CNT_W'(1);
                        if (remain_reg == CNT_W'(1)) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            base_reg  <= base_inc;
                            cur_reg   <= base_inc;
                            steps_reg <= '0;
                            ovf_reg   <= 1'b0;
                            err_reg   <= 1'b0;
`ifdef COLLATZ_PEAK_EN
                            peak_reg  <= base_inc;
`endif
                            state_reg <= ITER;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Result fields come straight from the working registers, which do not
    // change while EMIT waits for res_ready.
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.res_valid = valid_reg;
    assign bus.res_n     = base_reg;
    assign bus.res_steps = steps_reg;
    assign bus.res_ovf   = ovf_reg;
    assign bus.res_err   = err_reg;
`ifdef COLLATZ_PEAK_EN
    assign bus.res_peak  = peak_reg;
`else
    assign bus.res_peak  = '0;
`endif

endmodule

// File: tb/tb_collatz_range.sv
// -----------------------------------------------------------------------------
// tb_collatz_range
//   Directed bench for collatz_range. Three engines share clock and reset:
//     b   : WIDTH=32 STEP_W=16 (main)
//     b8  : WIDTH=8            (overflow / wrap)
//     b4  : STEP_W=4           (step saturation)
//   Expected values are hand-computed Collatz stopping times.
// -----------------------------------------------------------------------------
module tb_collatz_range;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    collatz_range_if #(.WIDTH(32), .STEP_W(16), .CNT_W(16)) b();
    collatz_range_if #(.WIDTH(8),  .STEP_W(16), .CNT_W(16)) b8();
    collatz_range_if #(.WIDTH(32), .STEP_W(4),  .CNT_W(16)) b4();

    collatz_range #(.WIDTH(32), .STEP_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(rst), .bus(b));
    collatz_range #(.WIDTH(8), .STEP_W(16), .CNT_W(16)) dut_w8 (
        .clk(clk), .reset(rst), .bus(b8));
    collatz_range #(.WIDTH(32), .STEP_W(4), .CNT_W(16)) dut_s4 (
        .clk(clk), .reset(rst), .bus(b4));

    // Wait (bounded) for res_valid on engine `which`; go lines are dropped at
    // every negedge so a request is a single-cycle pulse.
    task automatic wait_valid(input int which, input string tag, output int lat);
        bit v;
        lat = 0;
        do begin
            @(negedge clk);
            b.go = 1'b0; b8.go = 1'b0; b4.go = 1'b0;
            lat++;
            v = (which == 0) ? b.res_valid : (which == 1) ? b8.res_valid : b4.res_valid;
        end while (!v && lat < 400);
        if (!v) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: res_valid=0 after %0d cycles, required 1", tag, lat);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (b.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", b.busy); end
        vectors++; if (b.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b required 0", b.res_valid); end
        vectors++; if (b.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b required 0", b.done); end
        vectors++; if ({b.res_ovf, b.res_err} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b required 00", {b.res_ovf, b.res_err}); end
        vectors++; if (b.res_n !== 32'd0 || b.res_steps !== 16'd0 || b.res_peak !== 32'd0) begin
            miscompares++; $display("FAIL rst_fields: n=%0d steps=%0d peak=%0d required 0/0/0", b.res_n, b.res_steps, b.res_peak); end
        // Reset and go in the same cycle: reset wins.
        b.go = 1'b1; b.n = 32'd6; b.count = 16'd1;
        @(negedge clk);
        rst = 1'b0; b.go = 1'b0;
        vectors++; if (b.busy !== 1'b0) begin miscompares++; $display("FAIL rst_go_busy: got %b required 0", b.busy); end
        @(negedge clk);
        vectors++; if (b.busy !== 1'b0 || b.res_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_go_idle: busy=%b valid=%b required 0/0", b.busy, b.res_valid); end
    endtask

    task automatic test_single();
        int lat;
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd6; b.count = 16'd1; b.res_ready = 1'b1;
        wait_valid(0, "single", lat);
        vectors++; if (lat != 10) begin miscompares++; $display("FAIL single_latency: got %0d required 10", lat); end
        vectors++; if (b.res_n !== 32'd6 || b.res_steps !== 16'd8) begin
            miscompares++; $display("FAIL single_result: n=%0d steps=%0d required 6/8", b.res_n, b.res_steps); end
        vectors++; if ({b.res_ovf, b.res_err, b.busy} !== 3'b001) begin
            miscompares++; $display("FAIL single_flags: ovf/err/busy=%b required 001", {b.res_ovf, b.res_err, b.busy}); end
        @(negedge clk);
        vectors++; if ({b.res_valid, b.done, b.busy} !== 3'b010) begin
            miscompares++; $display("FAIL single_done: valid/done/busy=%b required 010", {b.res_valid, b.done, b.busy}); end
        @(negedge clk);
        vectors++; if (b.done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %b required 0", b.done); end
    endtask

    task automatic test_range();
        int lat;
        int exp_steps [4] = '{0, 1, 7, 2};
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd1; b.count = 16'd4; b.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(0, "range", lat);
            vectors++; if (b.res_n !== 32'(i + 1) || b.res_steps !== 16'(exp_steps[i])) begin
                miscompares++; $display("FAIL range_result%0d: n=%0d steps=%0d required %0d/%0d", i, b.res_n, b.res_steps, i + 1, exp_steps[i]); end
            vectors++; if (b.done !== 1'b0) begin miscompares++; $display("FAIL range_early_done%0d: got %b required 0", i, b.done); end
        end
        @(negedge clk);
        vectors++; if ({b.done, b.busy} !== 2'b10) begin
            miscompares++; $display("FAIL range_done: done/busy=%b required 10", {b.done, b.busy}); end
    endtask

    task automatic test_count_zero();
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd5; b.count = 16'd0;
        @(negedge clk);
        b.go = 1'b0;
        vectors++; if ({b.done, b.busy, b.res_valid} !== 3'b100) begin
            miscompares++; $display("FAIL zero_count: done/busy/valid=%b required 100", {b.done, b.busy, b.res_valid}); end
        @(negedge clk);
        vectors++; if ({b.done, b.busy} !== 2'b00) begin
            miscompares++; $display("FAIL zero_count_after: done/busy=%b required 00", {b.done, b.busy}); end
    endtask

    task automatic test_ovf_err();
        int lat;
        @(negedge clk);
        b8.go = 1'b1; b8.n = 8'd171; b8.count = 16'd1; b8.res_ready = 1'b1;
        wait_valid(1, "ovf", lat);
        vectors++; if ({b8.res_ovf, b8.res_err} !== 2'b10 || b8.res_steps !== 16'd0 || b8.res_n !== 8'd171) begin
            miscompares++; $display("FAIL ovf_171: ovf/err=%b steps=%0d n=%0d required 10/0/171", {b8.res_ovf, b8.res_err}, b8.res_steps, b8.res_n); end
        // 255 overflows at once; the next start value wraps to 0.
        @(negedge clk);
        b8.go = 1'b1; b8.n = 8'd255; b8.count = 16'd2;
        wait_valid(1, "wrap0", lat);
        vectors++; if ({b8.res_ovf, b8.res_err} !== 2'b10 || b8.res_n !== 8'd255) begin
            miscompares++; $display("FAIL wrap_255: ovf/err=%b n=%0d required 10/255", {b8.res_ovf, b8.res_err}, b8.res_n); end
        wait_valid(1, "wrap1", lat);
        vectors++; if ({b8.res_ovf, b8.res_err} !== 2'b01 || b8.res_n !== 8'd0 || b8.res_steps !== 16'd0) begin
            miscompares++; $display("FAIL wrap_0: ovf/err=%b n=%0d steps=%0d required 01/0/0", {b8.res_ovf, b8.res_err}, b8.res_n, b8.res_steps); end
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd0; b.count = 16'd1; b.res_ready = 1'b1;
        wait_valid(0, "err", lat);
        vectors++; if ({b.res_ovf, b.res_err} !== 2'b01 || b.res_steps !== 16'd0) begin
            miscompares++; $display("FAIL err_0: ovf/err=%b steps=%0d required 01/0", {b.res_ovf, b.res_err}, b.res_steps); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd3; b.count = 16'd2; b.res_ready = 1'b0;
        wait_valid(0, "bp", lat);
        for (int i = 0; i < 5; i++) begin
            // Request while busy must be ignored.
            b.go = 1'b1; b.n = 32'd100; b.count = 16'd1;
            @(negedge clk);
            vectors++; if (b.res_valid !== 1'b1 || b.res_n !== 32'd3 || b.res_steps !== 16'd7) begin
                miscompares++; $display("FAIL bp_hold%0d: valid=%b n=%0d steps=%0d required 1/3/7", i, b.res_valid, b.res_n, b.res_steps); end
        end
        b.go = 1'b0; b.res_ready = 1'b1;
        wait_valid(0, "bp2", lat);
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL bp_latency: got %0d required 4", lat); end
        vectors++; if (b.res_n !== 32'd4 || b.res_steps !== 16'd2) begin
            miscompares++; $display("FAIL bp_second: n=%0d steps=%0d required 4/2", b.res_n, b.res_steps); end
        @(negedge clk);
        vectors++; if (b.done !== 1'b1) begin miscompares++; $display("FAIL bp_done: got %b required 1", b.done); end
        repeat (3) @(negedge clk);
        vectors++; if ({b.busy, b.res_valid} !== 2'b00) begin
            miscompares++; $display("FAIL bp_ignored_go: busy/valid=%b required 00", {b.busy, b.res_valid}); end
    endtask

    task automatic test_saturate_peak();
        int lat;
        @(negedge clk);
        b4.go = 1'b1; b4.n = 32'd27; b4.count = 16'd1; b4.res_ready = 1'b1;
        wait_valid(2, "sat", lat);
        vectors++; if (b4.res_steps !== 4'd15 || {b4.res_ovf, b4.res_err} !== 2'b00) begin
            miscompares++; $display("FAIL sat_27: steps=%0d ovf/err=%b required 15/00", b4.res_steps, {b4.res_ovf, b4.res_err}); end
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd7; b.count = 16'd1; b.res_ready = 1'b1;
        wait_valid(0, "peak", lat);
        vectors++; if (b.res_steps !== 16'd16) begin miscompares++; $display("FAIL steps_7: got %0d required 16", b.res_steps); end
`ifdef COLLATZ_PEAK_EN
        vectors++; if (b.res_peak !== 32'd52) begin miscompares++; $display("FAIL peak_7: got %0d required 52", b.res_peak); end
`else
        vectors++; if (b.res_peak !== 32'd0) begin miscompares++; $display("FAIL peak_off: got %0d required 0", b.res_peak); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        b.go = 1'b1; b.n = 32'd27; b.count = 16'd3; b.res_ready = 1'b1;
        @(negedge clk);
        b.go = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (b.busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b required 1", b.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if ({b.busy, b.res_valid, b.done} !== 3'b000) begin
            miscompares++; $display("FAIL mid_reset: busy/valid/done=%b required 000", {b.busy, b.res_valid, b.done}); end
        repeat (3) @(negedge clk);
        vectors++; if ({b.busy, b.done} !== 2'b00) begin
            miscompares++; $display("FAIL mid_no_done: busy/done=%b required 00", {b.busy, b.done}); end
        b.go = 1'b1; b.n = 32'd6; b.count = 16'd1;
        wait_valid(0, "mid_rerun", lat);
        vectors++; if (lat != 10 || b.res_n !== 32'd6 || b.res_steps !== 16'd8) begin
            miscompares++; $display("FAIL mid_rerun: lat=%0d n=%0d steps=%0d required 10/6/8", lat, b.res_n, b.res_steps); end
        @(negedge clk);
        vectors++; if (b.done !== 1'b1) begin miscompares++; $display("FAIL mid_rerun_done: got %b required 1", b.done); end
    endtask

    initial begin
        b.go = 1'b0;  b.n = '0;  b.count = '0;  b.res_ready = 1'b0;
        b8.go = 1'b0; b8.n = '0; b8.count = '0; b8.res_ready = 1'b0;
        b4.go = 1'b0; b4.n = '0; b4.count = '0; b4.res_ready = 1'b0;
        test_reset();
        test_single();
        test_range();
        test_count_zero();
        test_ovf_err();
        test_back_to_back();
        test_saturate_peak();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
